// File: rtl/mem_access_unit_if.sv
// Request/response and data_memory bus for mem_access_unit.
// The slave side is the access unit; the master side is the pipeline plus data_memory.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_MemWrite;
   logic        mem_MemRead;
   logic [63:0] mem_read_data;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  stall, resp_valid, resp_rdata, resp_err,
      input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      output mem_read_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output stall, resp_valid, resp_rdata, resp_err,
      output mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      input  mem_read_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: 64-bit word accesses, RMW for sub-dword stores.
// Define MEM_ACCESS_SW_GUARD_EN to block stores to the switch word SW_WORD.
module mem_access_unit #(
   parameter int          ADDR_LSB = 3,
   parameter logic [63:0] SW_WORD  = 64'd21
) (
   input logic              clock,
   input logic              reset,
   mem_access_unit_if.slave bus
);

`ifdef MEM_ACCESS_SW_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LD_RESP, RMW_WR} state_t;

   state_t      state;
   logic [63:0] merged_q;
   logic [63:0] index_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [63:0] resp_rdata_q;

   logic [63:0] word_index;
   logic [5:0]  lane_shift;
   logic        misaligned;
   logic        blocked;
   logic        accept;
   logic        access_ok;
   logic        dword_store;
   logic        start_read;
   logic [63:0] size_mask;
   logic [63:0] lane_mask;
   logic [63:0] merged;
   logic [63:0] shifted_rd;
   logic [63:0] extended;

   assign word_index  = bus.req_addr >> ADDR_LSB;
   assign lane_shift  = {bus.req_addr[2:0], 3'b000};
   assign blocked     = GUARD_EN && bus.req_write && (word_index == SW_WORD);
   assign accept      = (state == IDLE) && bus.req_valid && !reset;
   assign access_ok   = accept && !misaligned && !blocked;
   assign dword_store = bus.req_write && (bus.req_size == 2'b11);
   assign start_read  = access_ok && !dword_store;

   // Alignment check, lane masks and load extension all key off the access size.
   always_comb begin
      misaligned = 1'b0;
      size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
      extended   = shifted_rd;
      case (bus.req_size)
         2'b00: begin
            size_mask = 64'h0000_0000_0000_00FF;
            extended  = {{56{bus.req_signed & shifted_rd[7]}}, shifted_rd[7:0]};
         end
         2'b01: begin
            misaligned = bus.req_addr[0];
            size_mask  = 64'h0000_0000_0000_FFFF;
            extended   = {{48{bus.req_signed & shifted_rd[15]}}, shifted_rd[15:0]};
         end
         2'b10: begin
            misaligned = |bus.req_addr[1:0];
            size_mask  = 64'h0000_0000_FFFF_FFFF;
            extended   = {{32{bus.req_signed & shifted_rd[31]}}, shifted_rd[31:0]};
         end
         default: begin
            misaligned = |bus.req_addr[2:0];
         end
      endcase
   end

   assign shifted_rd = bus.mem_read_data >> lane_shift;
   assign lane_mask  = size_mask << lane_shift;
   assign merged     = (bus.mem_read_data & ~lane_mask) | ((bus.req_wdata << lane_shift) & lane_mask);

   // Strobes are gated by reset so a reset in RMW_WR drops the pending write.
   assign bus.stall          = start_read;
   assign bus.mem_MemRead    = start_read;
   assign bus.mem_MemWrite   = (access_ok && dword_store) || ((state == RMW_WR) && !reset);
   assign bus.mem_address    = (state == RMW_WR) ? index_q  : word_index;
   assign bus.mem_write_data = (state == RMW_WR) ? merged_q : bus.req_wdata;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_err       = resp_err_q;
   assign bus.resp_rdata     = resp_rdata_q;

   // Requests are only taken in IDLE; the held request during LD_RESP/RMW_WR is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         merged_q     <= '0;
         index_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (misaligned || blocked) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else if (!bus.req_write) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= extended;
                     state        <= LD_RESP;
                  end else if (!dword_store) begin
                     merged_q <= merged;
                     index_q  <= word_index;
                     state    <= RMW_WR;
                  end
               end
            end
            LD_RESP: state <= IDLE;
            RMW_WR:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural data_memory.
// Expectations follow MEM_ACCESS_SW_GUARD_EN when it is defined for the build.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SW_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [63:0] data;
   } resp_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   logic clock;
   logic reset;
   logic init_mem;
   int   test_count;
   int   fail_count;

   logic [63:0] dmem    [0:63];
   logic [63:0] ref_mem [0:63];
   resp_t       resp_q[$];
   wr_t         wr_q[$];
   resp_t       mon_r;
   wr_t         mon_w;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] init_value(input int i);
      if (i == 2) return 64'h0000_0000_80FF_0000;
      if (i == 4) return 64'h1122_3344_5566_7788;
      return 64'h8C3A_F105_7E92_B46D ^ (64'(i) * 64'h0101_0101_0101_0101);
   endfunction

   // Behavioural data_memory: combinational read, write on the rising edge.
   always_comb bus.mem_read_data = dmem[bus.mem_address[5:0]];

   always @(posedge clock) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) dmem[i] <= init_value(i);
      end else if (bus.mem_MemWrite) begin
         dmem[bus.mem_address[5:0]] <= bus.mem_write_data;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one request at a negedge, holds it while stalled, and queues the expected outcome.
   task automatic applyStimulus(input bit wr, input logic [1:0] size, input bit sgn,
                                input logic [63:0] addr, input logic [63:0] wdata);
      int          nbytes;
      int          lane;
      int          idx;
      int          stalls;
      int          exp_stalls;
      bit          err;
      logic [63:0] word;
      logic [63:0] val;
      resp_t       r;
      wr_t         w;
      nbytes = 1 << size;
      lane   = int'(addr[2:0]);
      idx    = int'(addr[8:3]);
      err    = ((lane % nbytes) != 0) || (GUARD && wr && ((addr >> 3) == 64'd21));
      word   = ref_mem[idx];
      if (err) begin
         r.err = 1'b1; r.data = '0; resp_q.push_back(r);
         exp_stalls = 0;
      end else if (wr) begin
         for (int b = 0; b < nbytes; b++) word[8*(lane+b) +: 8] = wdata[8*b +: 8];
         ref_mem[idx] = word;
         w.addr = addr >> 3; w.data = word; wr_q.push_back(w);
         exp_stalls = (size == 2'b11) ? 0 : 1;
      end else begin
         val = '0;
         for (int b = 0; b < nbytes; b++) val[8*b +: 8] = word[8*(lane+b) +: 8];
         if (sgn && nbytes < 8 && val[8*nbytes-1])
            for (int b = nbytes; b < 8; b++) val[8*b +: 8] = 8'hFF;
         r.err = 1'b0; r.data = val; resp_q.push_back(r);
         exp_stalls = 1;
      end
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      stalls = 0;
      #1;
      while (bus.stall && stalls < 8) begin
         @(negedge clock);
         #1;
         stalls++;
      end
      checkOutput("stall_cycles", 64'(stalls), 64'(exp_stalls));
      @(negedge clock);
   endtask

   // Monitor: pop expectations whenever the DUT responds or writes memory.
   always @(negedge clock) begin
      #2;
      checkOutput("strobe_excl", {63'b0, bus.mem_MemRead & bus.mem_MemWrite}, 64'd0);
      if (bus.resp_valid) begin
         if (resp_q.size() == 0) begin
            checkOutput("resp_extra", 64'd1, 64'd0);
         end else begin
            mon_r = resp_q.pop_front();
            checkOutput("resp_err", {63'b0, bus.resp_err}, {63'b0, mon_r.err});
            checkOutput("resp_rdata", bus.resp_rdata, mon_r.data);
         end
      end else begin
         checkOutput("err_alone", {63'b0, bus.resp_err}, 64'd0);
      end
      if (bus.mem_MemWrite) begin
         if (wr_q.size() == 0) begin
            checkOutput("write_extra", bus.mem_address, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_w = wr_q.pop_front();
            checkOutput("write_addr", bus.mem_address, mon_w.addr);
            checkOutput("write_data", bus.mem_write_data, mon_w.data);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]  sz;
      logic [2:0]  ln;
      logic [63:0] saved;
      test_count     = 0;
      fail_count     = 0;
      reset          = 1'b1;
      init_mem       = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_value(i);
      repeat (2) @(negedge clock);
      #1;
      checkOutput("rst_stall",      {63'b0, bus.stall},        64'd0);
      checkOutput("rst_resp_valid", {63'b0, bus.resp_valid},   64'd0);
      checkOutput("rst_resp_err",   {63'b0, bus.resp_err},     64'd0);
      checkOutput("rst_resp_rdata", bus.resp_rdata,            64'd0);
      checkOutput("rst_memwrite",   {63'b0, bus.mem_MemWrite}, 64'd0);
      checkOutput("rst_memread",    {63'b0, bus.mem_MemRead},  64'd0);
      @(negedge clock);
      reset    = 1'b0;
      init_mem = 1'b0;

      applyStimulus(1'b0, 2'b00, 1'b1, 64'h13, '0);
      applyStimulus(1'b1, 2'b01, 1'b0, 64'h22, 64'hBEEF);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h20, '0);
      applyStimulus(1'b1, 2'b11, 1'b0, 64'h40, 64'hDEAD_BEEF_CAFE_F00D);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h40, '0);
      applyStimulus(1'b0, 2'b10, 1'b0, 64'h06, '0);
      applyStimulus(1'b0, 2'b01, 1'b1, 64'h0D, '0);
      applyStimulus(1'b1, 2'b11, 1'b0, 64'h44, 64'h1234_5678_9ABC_DEF0);
      applyStimulus(1'b0, 2'b01, 1'b0, 64'h16, '0);
      applyStimulus(1'b0, 2'b10, 1'b1, 64'h1C, '0);
      applyStimulus(1'b0, 2'b00, 1'b0, 64'h1F, '0);
      applyStimulus(1'b1, 2'b00, 1'b0, 64'h27, 64'hFFFF_FFFF_FFFF_FFA5);
      applyStimulus(1'b1, 2'b10, 1'b0, 64'h34, 64'h0BAD_F00D_8765_4321);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h20, '0);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h30, '0);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h1_0000_0028, '0);
      applyStimulus(1'b1, 2'b00, 1'b0, 64'hA8, 64'h5A);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'hA8, '0);

      // Reset lands in the RMW_WR cycle: the write must be dropped.
      saved          = ref_mem[11];
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 64'h58;
      bus.req_wdata  = 64'h77;
      #1;
      checkOutput("rmw_stall", {63'b0, bus.stall}, 64'd1);
      @(negedge clock);
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      checkOutput("rmw_rst_memwrite", {63'b0, bus.mem_MemWrite}, 64'd0);
      checkOutput("rmw_rst_stall",    {63'b0, bus.stall},        64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("rmw_rst_resp_valid", {63'b0, bus.resp_valid},   64'd0);
      checkOutput("rmw_rst_rdata",      bus.resp_rdata,            64'd0);
      checkOutput("rmw_rst_memread",    {63'b0, bus.mem_MemRead},  64'd0);
      checkOutput("rmw_rst_mem",        dmem[11],                  saved);
      @(negedge clock);
      applyStimulus(1'b0, 2'b11, 1'b0, 64'h58, '0);

      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(0, 3));
         ln = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) ln = ln & ~3'((1 << sz) - 1);
         applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                       {55'b0, 6'($urandom_range(0, 63)), ln}, {$urandom, $urandom});
      end

      bus.req_valid = 1'b0;
      repeat (4) @(negedge clock);
      #3;
      checkOutput("resp_q_left", 64'(resp_q.size()), 64'd0);
      checkOutput("wr_q_left",   64'(wr_q.size()),   64'd0);
      checkOutput("final_word4", dmem[4], ref_mem[4]);
      checkOutput("final_word8", dmem[8], ref_mem[8]);
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
